// File: rtl/bp_be_cache_req_arb.sv
// ---------------------------------------------------------------------------
// bp_be_cache_req_arb
//
// Round-robin arbiter that funnels several cache-request channels onto one
// LCE request port. A transaction is a request beat, then a metadata beat,
// then a completion from the LCE. Only one transaction is in flight at a
// time. The completion is returned as a one-cycle pulse to the channel that
// owns the transaction.
//
// Ports
//   clk_i                  : clock, rising edge
//   reset_i                : asynchronous active-low reset
//   req_i / req_v_i        : per-channel request data / valid
//   req_ready_o            : per-channel accept (only the selected channel)
//   req_metadata_i / _v_i  : per-channel metadata data / valid
//   req_complete_o         : per-channel completion pulse
//   cache_req_o / _v_o     : request to LCE (valid only while ready is high)
//   cache_req_ready_i      : LCE ready
//   cache_req_metadata_o/_v_o : metadata of the granted channel to LCE
//   cache_req_complete_i   : LCE completion of the in-flight request
//   grant_id_o             : channel owning the in-flight request
//   busy_o                 : a transaction is in flight
//   error_o                : sticky protocol-error flag
// ---------------------------------------------------------------------------
module bp_be_cache_req_arb #(
    parameter int num_req_p        = 2,
    parameter int req_width_p      = 64,
    parameter int metadata_width_p = 8,
    localparam int id_width_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,

    input  logic [num_req_p*req_width_p-1:0]      req_i,
    input  logic [num_req_p-1:0]                  req_v_i,
    output logic [num_req_p-1:0]                  req_ready_o,
    input  logic [num_req_p*metadata_width_p-1:0] req_metadata_i,
    input  logic [num_req_p-1:0]                  req_metadata_v_i,
    output logic [num_req_p-1:0]                  req_complete_o,

    output logic [req_width_p-1:0]                cache_req_o,
    output logic                                  cache_req_v_o,
    input  logic                                  cache_req_ready_i,
    output logic [metadata_width_p-1:0]           cache_req_metadata_o,
    output logic                                  cache_req_metadata_v_o,
    input  logic                                  cache_req_complete_i,

    output logic [id_width_lp-1:0]                grant_id_o,
    output logic                                  busy_o,
    output logic                                  error_o
);

    localparam int unsigned n_lp = num_req_p;
    localparam logic [id_width_lp-1:0] last_init_lp = id_width_lp'(num_req_p - 1);

    typedef enum logic [1:0] {
        e_ready,
        e_metadata,
        e_wait_complete
    } state_e;

    state_e                  state_r, state_n;
    logic [id_width_lp-1:0]  grant_id_r, grant_id_n;
    logic [id_width_lp-1:0]  last_grant_r, last_grant_n;
    logic                    error_r, error_n;

    // Round-robin pick: channels above last_grant first, then wrap to the
    // channels at or below it. Equivalent to scanning from last_grant+1.
    logic                    sel_v;
    logic [id_width_lp-1:0]  sel_id;

    always_comb begin
        sel_v  = 1'b0;
        sel_id = '0;
        for (int unsigned k = 0; k < n_lp; k++) begin
            if (!sel_v && req_v_i[k] && (id_width_lp'(k) > last_grant_r)) begin
                sel_v  = 1'b1;
                sel_id = id_width_lp'(k);
            end
        end
        for (int unsigned k = 0; k < n_lp; k++) begin
            if (!sel_v && req_v_i[k] && (id_width_lp'(k) <= last_grant_r)) begin
                sel_v  = 1'b1;
                sel_id = id_width_lp'(k);
            end
        end
    end

    // Data and one-hot steering for the selected / granted channel.
    logic [req_width_p-1:0]      sel_req;
    logic [num_req_p-1:0]        sel_onehot;
    logic [metadata_width_p-1:0] grant_md;
    logic                        grant_md_v;
    logic [num_req_p-1:0]        grant_onehot;

    always_comb begin
        sel_req      = '0;
        sel_onehot   = '0;
        grant_md     = '0;
        grant_md_v   = 1'b0;
        grant_onehot = '0;
        for (int unsigned k = 0; k < n_lp; k++) begin
            if (sel_id == id_width_lp'(k)) begin
                sel_req       = req_i[k*req_width_p +: req_width_p];
                sel_onehot[k] = 1'b1;
            end
            if (grant_id_r == id_width_lp'(k)) begin
                grant_md        = req_metadata_i[k*metadata_width_p +: metadata_width_p];
                grant_md_v      = req_metadata_v_i[k];
                grant_onehot[k] = 1'b1;
            end
        end
    end

    // Next-state and outputs.
    always_comb begin
        state_n                = state_r;
        grant_id_n             = grant_id_r;
        last_grant_n           = last_grant_r;
        error_n                = error_r;
        req_ready_o            = '0;
        req_complete_o         = '0;
        cache_req_o            = '0;
        cache_req_v_o          = 1'b0;
        cache_req_metadata_o   = '0;
        cache_req_metadata_v_o = 1'b0;

        case (state_r)
            e_ready: begin
                if (cache_req_complete_i) begin
                    error_n = 1'b1;
                end
                if (cache_req_ready_i && sel_v) begin
                    cache_req_v_o = 1'b1;
                    cache_req_o   = sel_req;
                    req_ready_o   = sel_onehot;
                    grant_id_n    = sel_id;
                    last_grant_n  = sel_id;
                    state_n       = e_metadata;
                end
            end

            e_metadata: begin
                cache_req_metadata_o   = grant_md;
                cache_req_metadata_v_o = grant_md_v;
                if (cache_req_complete_i) begin
                    // Completion without metadata is a protocol error, but
                    // the owner is still released so it cannot hang.
                    if (!grant_md_v) begin
                        error_n = 1'b1;
                    end
                    req_complete_o = grant_onehot;
                    state_n        = e_ready;
                end else if (grant_md_v) begin
                    state_n = e_wait_complete;
                end
            end

            e_wait_complete: begin
                if (cache_req_complete_i) begin
                    req_complete_o = grant_onehot;
                    state_n        = e_ready;
                end
            end

            default: begin
                state_n = e_ready;
            end
        endcase

        // Combinational outputs are held low while reset is asserted.
        if (!reset_i) begin
            req_ready_o            = '0;
            req_complete_o         = '0;
            cache_req_o            = '0;
            cache_req_v_o          = 1'b0;
            cache_req_metadata_o   = '0;
            cache_req_metadata_v_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r      <= e_ready;
            grant_id_r   <= '0;
            last_grant_r <= last_init_lp;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_n;
            grant_id_r   <= grant_id_n;
            last_grant_r <= last_grant_n;
            error_r      <= error_n;
        end
    end

    assign grant_id_o = grant_id_r;
    assign busy_o     = (state_r != e_ready);
    assign error_o    = error_r;

endmodule

// File: tb/tb_bp_be_cache_req_arb.sv
module tb_bp_be_cache_req_arb;

    localparam int N = 2;
    localparam int W = 64;
    localparam int M = 8;

    logic             clk = 1'b0;
    logic             reset_i;
    logic [N*W-1:0]   req_i;
    logic [N-1:0]     req_v_i;
    logic [N-1:0]     req_ready_o;
    logic [N*M-1:0]   req_metadata_i;
    logic [N-1:0]     req_metadata_v_i;
    logic [N-1:0]     req_complete_o;
    logic [W-1:0]     cache_req_o;
    logic             cache_req_v_o;
    logic             cache_req_ready_i;
    logic [M-1:0]     cache_req_metadata_o;
    logic             cache_req_metadata_v_o;
    logic             cache_req_complete_i;
    logic [0:0]       grant_id_o;
    logic             busy_o;
    logic             error_o;

    always #5 clk = ~clk;

    bp_be_cache_req_arb #(
        .num_req_p(N),
        .req_width_p(W),
        .metadata_width_p(M)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .req_i(req_i),
        .req_v_i(req_v_i),
        .req_ready_o(req_ready_o),
        .req_metadata_i(req_metadata_i),
        .req_metadata_v_i(req_metadata_v_i),
        .req_complete_o(req_complete_o),
        .cache_req_o(cache_req_o),
        .cache_req_v_o(cache_req_v_o),
        .cache_req_ready_i(cache_req_ready_i),
        .cache_req_metadata_o(cache_req_metadata_o),
        .cache_req_metadata_v_o(cache_req_metadata_v_o),
        .cache_req_complete_i(cache_req_complete_i),
        .grant_id_o(grant_id_o),
        .busy_o(busy_o),
        .error_o(error_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({req_ready_o, req_complete_o, cache_req_o, cache_req_v_o,
                     cache_req_metadata_o, cache_req_metadata_v_o, grant_id_o, busy_o, error_o});
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_i              = 1'b0;
        req_v_i              = '0;
        req_metadata_v_i     = '0;
        cache_req_ready_i    = 1'b0;
        cache_req_complete_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b1;
    endtask

    task automatic drive(input logic [1:0] rv, input logic rdy, input logic [1:0] mdv, input logic cmp);
        @(negedge clk);
        req_v_i              = rv;
        cache_req_ready_i    = rdy;
        req_metadata_v_i     = mdv;
        cache_req_complete_i = cmp;
        #1;
    endtask

    // Directed vector table
    typedef struct {
        logic [1:0] rv;
        logic       rdy;
        logic [1:0] mdv;
        logic       cmp;
        logic [1:0] e_rr;
        logic       e_cv;
        logic       e_gid;
        logic       e_busy;
        logic       e_mdv;
        logic [1:0] e_cmp;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] rv, input logic rdy, input logic [1:0] mdv,
                                input logic cmp, input logic [1:0] e_rr, input logic e_cv,
                                input logic e_gid, input logic e_busy, input logic e_mdv,
                                input logic [1:0] e_cmp);
        vec_t v;
        v.rv = rv; v.rdy = rdy; v.mdv = mdv; v.cmp = cmp;
        v.e_rr = e_rr; v.e_cv = e_cv; v.e_gid = e_gid; v.e_busy = e_busy;
        v.e_mdv = e_mdv; v.e_cmp = e_cmp;
        return v;
    endfunction

    localparam logic [W-1:0] D0 = 64'hA0A0_1111_A0A0_2222;
    localparam logic [W-1:0] D1 = 64'hB1B1_3333_B1B1_4444;
    localparam logic [M-1:0] MD0 = 8'h50;
    localparam logic [M-1:0] MD1 = 8'h61;

    // Behavioural reference: transaction owner (-1 when idle), whether the
    // metadata beat was seen, last granted channel, sticky error.
    int   m_owner, m_last, m_gid;
    bit   m_md_seen, m_err;

    function automatic int rr_pick(input logic [1:0] rv, input int last);
        int best, bestd, d;
        best  = -1;
        bestd = N;
        for (int k = 0; k < N; k++) begin
            if (rv[k]) begin
                d = (k - last - 1 + 2 * N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = k;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_last    = N - 1;
        m_gid     = 0;
        m_md_seen = 1'b0;
        m_err     = 1'b0;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        logic [W-1:0] exp_req;
        logic [M-1:0] exp_md;

        reset_i              = 1'b0;
        req_i                = {D1, D0};
        req_metadata_i       = {MD1, MD0};
        req_v_i              = 2'b11;
        req_metadata_v_i     = 2'b11;
        cache_req_ready_i    = 1'b1;
        cache_req_complete_i = 1'b1;
        #3;
        chk("reset_outputs_zero", all_outs(), '0);
        @(negedge clk);
        chk("reset_outputs_zero_held", all_outs(), '0);
        req_v_i = '0; req_metadata_v_i = '0; cache_req_ready_i = 1'b0; cache_req_complete_i = 1'b0;
        reset_i = 1'b1;

        //            rv     rdy   mdv    cmp  | rr     cv    gid   busy  mdvo  cmpo
        tbl.push_back(mk(2'b11, 1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00));
        tbl.push_back(mk(2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk(2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk(2'b11, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01));
        tbl.push_back(mk(2'b11, 1'b1, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(2'b11, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00));
        tbl.push_back(mk(2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk(2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk(2'b11, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10));
        tbl.push_back(mk(2'b11, 1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(2'b00, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(2'b10, 1'b1, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(2'b00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk(2'b00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk(2'b00, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00));
        tbl.push_back(mk(2'b11, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10));
        tbl.push_back(mk(2'b11, 1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk(2'b00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00));
        tbl.push_back(mk(2'b00, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v.rv, v.rdy, v.mdv, v.cmp);
            chk($sformatf("tbl%0d_req_ready", i), 128'(req_ready_o), 128'(v.e_rr));
            chk($sformatf("tbl%0d_cache_req_v", i), 128'(cache_req_v_o), 128'(v.e_cv));
            if (v.e_cv) begin
                exp_req = v.e_rr[1] ? D1 : D0;
                chk($sformatf("tbl%0d_cache_req", i), 128'(cache_req_o), 128'(exp_req));
            end
            chk($sformatf("tbl%0d_grant_id", i), 128'(grant_id_o), 128'(v.e_gid));
            chk($sformatf("tbl%0d_busy", i), 128'(busy_o), 128'(v.e_busy));
            chk($sformatf("tbl%0d_md_v", i), 128'(cache_req_metadata_v_o), 128'(v.e_mdv));
            if (v.e_mdv) begin
                exp_md = v.e_gid ? MD1 : MD0;
                chk($sformatf("tbl%0d_md", i), 128'(cache_req_metadata_o), 128'(exp_md));
            end
            chk($sformatf("tbl%0d_complete", i), 128'(req_complete_o), 128'(v.e_cmp));
            chk($sformatf("tbl%0d_error", i), 128'(error_o), 128'd0);
        end

        // Completion while idle: sticky error, no pulse.
        do_reset();
        drive(2'b00, 1'b0, 2'b00, 1'b1);
        chk("idle_cmp_no_pulse", 128'(req_complete_o), 128'd0);
        chk("idle_cmp_err_not_yet", 128'(error_o), 128'd0);
        drive(2'b00, 1'b0, 2'b00, 1'b0);
        chk("idle_cmp_err_set", 128'(error_o), 128'd1);
        repeat (4) drive(2'b00, 1'b0, 2'b00, 1'b0);
        chk("idle_cmp_err_sticky", 128'(error_o), 128'd1);
        drive(2'b10, 1'b1, 2'b00, 1'b0);
        chk("after_err_grant_v", 128'(cache_req_v_o), 128'd1);
        chk("after_err_grant_rr", 128'(req_ready_o), 128'(2'b10));

        // Reset asserted while waiting for completion.
        do_reset();
        drive(2'b01, 1'b1, 2'b00, 1'b0);
        drive(2'b00, 1'b1, 2'b01, 1'b0);
        drive(2'b00, 1'b1, 2'b00, 1'b0);
        chk("midrst_busy_before", 128'(busy_o), 128'd1);
        #2;
        reset_i = 1'b0;
        #1;
        chk("midrst_busy_drop", 128'(busy_o), 128'd0);
        cache_req_complete_i = 1'b1;
        #1;
        chk("midrst_outputs_zero", all_outs(), '0);
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        chk("midrst_cmp_no_pulse", 128'(req_complete_o), 128'd0);
        drive(2'b00, 1'b0, 2'b00, 1'b0);
        chk("midrst_cmp_err", 128'(error_o), 128'd1);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [1:0] rv, mdv, exp_rr, exp_cmp;
            logic       rdy, cmp, exp_cv, exp_mdv;
            int         s;

            @(negedge clk);
            rv  = 2'($urandom);
            mdv = 2'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            cmp = (m_owner >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            req_i                = {$urandom, $urandom, $urandom, $urandom};
            req_metadata_i       = 16'($urandom);
            req_v_i              = rv;
            req_metadata_v_i     = mdv;
            cache_req_ready_i    = rdy;
            cache_req_complete_i = cmp;

            if ($urandom_range(0, 99) == 0) begin
                reset_i = 1'b0;
                #1;
                chk("rnd_reset_outputs", all_outs(), '0);
                model_reset();
                continue;
            end
            reset_i = 1'b1;
            #1;

            exp_rr = '0; exp_cv = 1'b0; exp_mdv = 1'b0; exp_cmp = '0; s = -1;
            if (m_owner < 0) begin
                s = rr_pick(rv, m_last);
                if (rdy && s >= 0) begin
                    exp_cv    = 1'b1;
                    exp_rr[s] = 1'b1;
                end
            end else begin
                if (!m_md_seen) exp_mdv = mdv[m_owner];
                if (cmp) exp_cmp[m_owner] = 1'b1;
            end

            chk("rnd_req_ready", 128'(req_ready_o), 128'(exp_rr));
            chk("rnd_cache_req_v", 128'(cache_req_v_o), 128'(exp_cv));
            if (exp_cv)
                chk("rnd_cache_req", 128'(cache_req_o), 128'(req_i[s*W +: W]));
            chk("rnd_md_v", 128'(cache_req_metadata_v_o), 128'(exp_mdv));
            if (m_owner >= 0 && !m_md_seen)
                chk("rnd_md", 128'(cache_req_metadata_o), 128'(req_metadata_i[m_owner*M +: M]));
            chk("rnd_complete", 128'(req_complete_o), 128'(exp_cmp));
            chk("rnd_busy", 128'(busy_o), 128'(m_owner >= 0));
            chk("rnd_grant_id", 128'(grant_id_o), 128'(m_gid));
            chk("rnd_error", 128'(error_o), 128'(m_err));

            if (m_owner < 0) begin
                if (cmp) m_err = 1'b1;
                if (exp_cv) begin
                    m_owner   = s;
                    m_gid     = s;
                    m_last    = s;
                    m_md_seen = 1'b0;
                end
            end else if (!m_md_seen) begin
                if (cmp) begin
                    if (!mdv[m_owner]) m_err = 1'b1;
                    m_owner = -1;
                end else if (mdv[m_owner]) begin
                    m_md_seen = 1'b1;
                end
            end else if (cmp) begin
                m_owner = -1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_be_cache_req_arb.md
BP_BE_CACHE_REQ_ARB -- requirements
Module: bp_be_cache_req_arb

Interface
REQ-001 SHALL have parameter num_req_p, default 2: number of requesting cache-request channels (1..8).
REQ-002 SHALL have parameter req_width_p, default 64: width of one cache request.
REQ-003 SHALL have parameter metadata_width_p, default 8: width of one request-metadata word.
REQ-004 SHALL define local id_width_lp = max(1, clog2(num_req_p)).
REQ-005 SHALL have port clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_i  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_i  in  num_req_p*req_width_p  per-channel requests; channel k at bits [k*req_width_p +: req_width_p].
REQ-008 SHALL have port req_v_i  in  num_req_p  per-channel request valid.
REQ-009 SHALL have port req_ready_o  out  num_req_p  per-channel accept; a transfer occurs when req_v_i[k] & req_ready_o[k].
REQ-010 SHALL have port req_metadata_i  in  num_req_p*metadata_width_p  per-channel metadata, same packing as req_i.
REQ-011 SHALL have port req_metadata_v_i  in  num_req_p  per-channel metadata valid.
REQ-012 SHALL have port req_complete_o  out  num_req_p  one-cycle completion pulse to the owning channel.
REQ-013 SHALL have port cache_req_o  out  req_width_p  request to LCE.
REQ-014 SHALL have port cache_req_v_o  out  1  request valid to LCE.
REQ-015 SHALL have port cache_req_ready_i  in  1  LCE ready; ready-then-valid (valid only raised while ready high).
REQ-016 SHALL have port cache_req_metadata_o  out  metadata_width_p  metadata to LCE.
REQ-017 SHALL have port cache_req_metadata_v_o  out  1  metadata valid to LCE.
REQ-018 SHALL have port cache_req_complete_i  in  1  LCE completion of the in-flight request.
REQ-019 SHALL have port grant_id_o  out  id_width_lp  channel owning the in-flight request.
REQ-020 SHALL have port busy_o  out  1  high whenever FSM is not e_ready.
REQ-021 SHALL have port error_o  out  1  sticky protocol-error flag.

Function
REQ-022 SHALL implement FSM states e_ready, e_metadata, e_wait_complete.
REQ-023 In e_ready, SHALL select the first channel with req_v_i set, searching round-robin starting at (last_grant+1) mod num_req_p.
REQ-024 In e_ready with cache_req_ready_i=1 and a selected channel k: cache_req_v_o=1, cache_req_o=req_i[k], req_ready_o[k]=1, all other req_ready_o=0 (zero-latency combinational pass-through).
REQ-025 On that transfer SHALL register grant_id=k, last_grant=k, and enter e_metadata.
REQ-026 In e_ready with cache_req_ready_i=0 or no valid channel: cache_req_v_o=0, req_ready_o=0.
REQ-027 In e_metadata/e_wait_complete: req_ready_o=0, cache_req_v_o=0.
REQ-028 In e_metadata: cache_req_metadata_o=req_metadata_i[grant_id], cache_req_metadata_v_o=req_metadata_v_i[grant_id]; metadata valid of other channels SHALL be ignored.
REQ-029 e_metadata -> e_wait_complete when granted metadata valid and cache_req_complete_i=0; -> e_ready when both set in same cycle, with req_complete_o[grant_id] pulsed.
REQ-030 e_metadata with cache_req_complete_i=1 and no metadata valid: SHALL set error_o, pulse req_complete_o[grant_id], return to e_ready.
REQ-031 e_wait_complete -> e_ready on cache_req_complete_i, pulsing req_complete_o[grant_id] that cycle (combinational).
REQ-032 cache_req_complete_i in e_ready SHALL set error_o and produce no req_complete_o pulse.
REQ-033 A new request SHALL NOT be granted in the same cycle completion returns the FSM to e_ready.
REQ-034 error_o SHALL remain set until reset.
REQ-035 With num_req_p=1 SHALL degenerate to a single pass-through channel, grant_id_o=0.

Reset
REQ-036 Reset assertion (reset_i=0) SHALL asynchronously force e_ready, grant_id=0, last_grant=num_req_p-1, error_o=0.
REQ-037 During reset all outputs SHALL be 0; reset mid-transaction SHALL drop it with no req_complete_o pulse.
REQ-038 First grant after reset SHALL search from channel 0.

Verification
REQ-039 num_req_p=2, both req_v_i=1 held, ready=1, metadata next cycle, complete 3 cycles later, repeated -> grants alternate 0,1,0,1; each req_complete_o pulse on matching channel.
REQ-040 Channel 1 request, cache_req_ready_i=0 for 4 cycles then 1 -> cache_req_v_o and req_ready_o[1] stay 0 until ready, then transfer in that cycle, grant_id_o=1.
REQ-041 Metadata valid and cache_req_complete_i same cycle in e_metadata -> req_complete_o pulses, FSM e_ready next cycle, error_o=0.
REQ-042 cache_req_complete_i while idle -> error_o=1 next cycle and stays 1; no req_complete_o.
REQ-043 reset_i=0 asserted in e_wait_complete -> busy_o=0 immediately, later complete produces no pulse and sets error_o after reset release.
REQ-044 Channel 0 metadata_v pulsed while channel 1 granted in e_metadata -> cache_req_metadata_v_o stays 0.
